fir_ch_scheduler: RTL and testbench

- Time-multiplexed multi-channel FIR controller. One serial shift-and-add datapath with taps H=[1, 0.5, 0.25, 0.125] and a final >>>2 is shared between NUM_CH sample streams.
- Round-robin arbitration picks the channel; the block holds per-channel history and sequences one tap per cycle.
- Sits between the per-channel sample sources and the downstream sample sink. Each output sample is tagged with its channel.

---
 rtl/fir_pkg.sv | 20 ++
 rtl/fir_rr_arbiter.sv | 31 +++
 rtl/fir_ch_scheduler.sv | 148 ++++++++++++++
 tb/tb_fir_ch_scheduler.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants and FSM encoding for the multi-channel FIR scheduler.
// Used by fir_ch_scheduler and fir_rr_arbiter.
package fir_pkg;

   localparam int DEF_WIDTH    = 16;
   localparam int DEF_NUM_TAPS = 4;
   localparam int DEF_NUM_CH   = 4;

   // Headroom bits above WIDTH so the tap sum never wraps
   localparam int ACC_GUARD   = 2;
   // Final normalising arithmetic right shift
   localparam int FINAL_SHIFT = 2;

   typedef enum logic [1:0] {
      IDLE,
      MAC,
      DONE
   } state_t;

endpackage

// File: rtl/fir_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr,
// wrapping; one-hot grant plus binary index.
module fir_rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   // Scan from the pointer upward and stop at the first request
   always_comb begin
      logic [IDX_W-1:0] c;
      c     = '0;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      for (int i = 0; i < N; i++) begin
         c = IDX_W'((int'(ptr) + i) % N);
         if (!any && req[c]) begin
            any      = 1'b1;
            grant[c] = 1'b1;
            idx      = c;
         end
      end
   end

endmodule

// File: rtl/fir_ch_scheduler.sv
// Time-multiplexed FIR controller: one shift-and-add tap per cycle shared
// by NUM_CH channels. Define FIR_BYPASS_EN to add the bypass input.
module fir_ch_scheduler
   import fir_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int NUM_TAPS = DEF_NUM_TAPS,
   parameter int NUM_CH   = DEF_NUM_CH,
   parameter int CH_W     = $clog2(DEF_NUM_CH)
) (
   input  logic                    clk,
   input  logic                    arst_n,
`ifdef FIR_BYPASS_EN
   input  logic                    bypass,
`endif
   input  logic [NUM_CH-1:0]       in_valid,
   input  logic [NUM_CH*WIDTH-1:0] in_data,
   output logic [NUM_CH-1:0]       in_ready,
   output logic                    out_valid,
   output logic [WIDTH-1:0]        out_data,
   output logic [CH_W-1:0]         out_ch,
   input  logic                    out_ready,
   output logic                    busy
);

   localparam int ACC_W = WIDTH + ACC_GUARD;
   localparam int TAP_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;

   state_t state, state_nx;

   logic [NUM_CH-1:0]       grant;
   logic [CH_W-1:0]         gnt_idx;
   logic                    gnt_any;
   logic                    accept;
   logic                    skip;
   logic                    last_tap;
   logic                    shift_en;
   logic [CH_W-1:0]         shift_ch;
   logic signed [WIDTH-1:0] shift_val;
   logic signed [WIDTH-1:0] in_smp;
   logic signed [WIDTH-1:0] opnd;
   logic signed [WIDTH-1:0] scaled;
   logic signed [ACC_W-1:0] term;

   logic [CH_W-1:0]         ptr;
   logic [CH_W-1:0]         ch_q;
   logic signed [WIDTH-1:0] smp_q;
   logic signed [ACC_W-1:0] acc;
   logic [TAP_W-1:0]        tap;
   logic signed [WIDTH-1:0] hist [NUM_CH][NUM_TAPS-1];

   fir_rr_arbiter #(
      .N     (NUM_CH),
      .IDX_W (CH_W)
   ) u_arb (
      .req   (in_valid),
      .ptr   (ptr),
      .grant (grant),
      .idx   (gnt_idx),
      .any   (gnt_any)
   );

`ifdef FIR_BYPASS_EN
   assign skip = bypass;
`else
   assign skip = 1'b0;
`endif

   assign accept   = (state == IDLE) && gnt_any;
   assign last_tap = (tap == TAP_W'(NUM_TAPS - 1));
   assign in_smp   = in_data[gnt_idx*WIDTH +: WIDTH];

   // History shifts as the result enters DONE (from MAC, or directly on bypass)
   assign shift_en  = ((state == MAC) && last_tap) || (accept && skip);
   assign shift_ch  = (state == IDLE) ? gnt_idx : ch_q;
   assign shift_val = (state == IDLE) ? in_smp : smp_q;

   assign out_valid = (state == DONE);
   assign out_data  = acc[FINAL_SHIFT +: WIDTH];
   assign out_ch    = ch_q;
   assign busy      = (state != IDLE);

   // Tap operand: new sample for tap 0, older history for later taps
   always_comb begin
      opnd = smp_q;
      for (int k = 1; k < NUM_TAPS; k++) begin
         if (tap == TAP_W'(k)) opnd = hist[ch_q][k-1];
      end
      scaled = opnd >>> tap;
      term   = {{ACC_GUARD{scaled[WIDTH-1]}}, scaled};
   end

   // State register
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) state <= IDLE;
      else         state <= state_nx;
   end

   // Next state and handshake towards the sources
   always_comb begin
      state_nx = state;
      in_ready = '0;
      unique case (state)
         IDLE: begin
            in_ready = grant;
            if (gnt_any) state_nx = skip ? DONE : MAC;
         end
         MAC:  if (last_tap) state_nx = DONE;
         DONE: if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Accept latch, round-robin pointer and tap accumulation
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         ptr   <= '0;
         ch_q  <= '0;
         smp_q <= '0;
         acc   <= '0;
         tap   <= '0;
      end else if (accept) begin
         ptr   <= CH_W'((int'(gnt_idx) + 1) % NUM_CH);
         ch_q  <= gnt_idx;
         smp_q <= in_smp;
         acc   <= skip ? ({{ACC_GUARD{in_smp[WIDTH-1]}}, in_smp} <<< FINAL_SHIFT)
                       : '0;
         tap   <= '0;
      end else if (state == MAC) begin
         acc <= acc + term;
         tap <= tap + 1'b1;
      end
   end

   // Per-channel sample history; only the served channel moves
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         for (int c = 0; c < NUM_CH; c++)
            for (int k = 0; k < NUM_TAPS-1; k++)
               hist[c][k] <= '0;
      end else if (shift_en) begin
         for (int k = NUM_TAPS-2; k >= 1; k--)
            hist[shift_ch][k] <= hist[shift_ch][k-1];
         hist[shift_ch][0] <= shift_val;
      end
   end

endmodule

// File: tb/tb_fir_ch_scheduler.sv
// Directed self-checking bench for fir_ch_scheduler (default build).
// Table-driven filter vectors plus hand-written multi-cycle sequences.
module tb_fir_ch_scheduler;

   logic        clk = 1'b0;
   logic        arst_n;
   logic [3:0]  in_valid;
   logic [63:0] in_data;
   logic [3:0]  in_ready;
   logic        out_valid;
   logic [15:0] out_data;
   logic [1:0]  out_ch;
   logic        out_ready;
   logic        busy;

   int n_chk  = 0;
   int n_fail = 0;

   fir_ch_scheduler dut (
      .clk       (clk),
      .arst_n    (arst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_ready (out_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          ch;
      logic [15:0] din;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs [13];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int ch, input logic [15:0] d);
      int n;
      n = 0;
      in_valid[ch]          = 1'b1;
      in_data[ch*16 +: 16]  = d;
      #1;
      while (!in_ready[ch] && n < 50) begin
         step();
         n++;
      end
      if (!in_ready[ch]) begin
         n_chk++;
         n_fail++;
         $display("FAIL send_timeout: ch %0d got no in_ready", ch);
      end
      step();
      in_valid[ch] = 1'b0;
   endtask

   task automatic wait_out(output int n);
      n = 0;
      while (!out_valid && n < 50) begin
         step();
         n++;
      end
      if (!out_valid) begin
         n_chk++;
         n_fail++;
         $display("FAIL out_timeout: got no out_valid");
      end
   endtask

   initial begin
      int n;
      int acc_cyc [$];
      int acc_ch  [$];
      int out_seq [$];
      int multi;

      vecs[0]  = '{0, 16'h0100, 16'h0040};
      vecs[1]  = '{0, 16'h0000, 16'h0020};
      vecs[2]  = '{0, 16'h0000, 16'h0010};
      vecs[3]  = '{0, 16'h0000, 16'h0008};
      vecs[4]  = '{0, 16'h0000, 16'h0000};
      vecs[5]  = '{1, 16'hFFFC, 16'hFFFF};
      vecs[6]  = '{1, 16'hFFFC, 16'hFFFE};
      vecs[7]  = '{1, 16'hFFFC, 16'hFFFE};
      vecs[8]  = '{1, 16'hFFFC, 16'hFFFE};
      vecs[9]  = '{2, 16'h7FFF, 16'h1FFF};
      vecs[10] = '{2, 16'h7FFF, 16'h2FFF};
      vecs[11] = '{2, 16'h7FFF, 16'h37FF};
      vecs[12] = '{2, 16'h7FFF, 16'h3BFF};

      arst_n    = 1'b0;
      in_valid  = '0;
      in_data   = '0;
      out_ready = 1'b1;
      #3;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_out_ch", 32'(out_ch), 0);
      step();
      step();
      arst_n = 1'b1;
      step();

      // Filter vectors
      for (int i = 0; i < 13; i++) begin
         send(vecs[i].ch, vecs[i].din);
         if (i == 0) chk("busy_in_mac", 32'(busy), 1);
         wait_out(n);
         if (i == 0) chk("latency", 32'(n), 4);
         chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].exp));
         chk($sformatf("vec%0d_ch", i), 32'(out_ch), 32'(vecs[i].ch));
         step();
         chk($sformatf("vec%0d_drop", i), 32'(out_valid), 0);
      end

      // Backpressure: ch3 result held while ch0 waits
      out_ready = 1'b0;
      send(3, 16'h0100);
      in_valid[0]      = 1'b1;
      in_data[0 +: 16] = 16'h0200;
      wait_out(n);
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 32'(out_valid), 1);
         chk("bp_data", 32'(out_data), 32'h0040);
         chk("bp_ch", 32'(out_ch), 3);
         chk("bp_in_ready", 32'(in_ready), 0);
         step();
      end
      out_ready = 1'b1;
      step();
      chk("bp_release", 32'(out_valid), 0);
      chk("bp_ch0_grant", 32'(in_ready), 32'h1);
      step();
      in_valid[0] = 1'b0;
      wait_out(n);
      chk("bp_wait_data", 32'(out_data), 32'h0080);
      chk("bp_wait_ch", 32'(out_ch), 0);
      step();

      // Reset during tap 2, history must be cleared
      send(0, 16'h0100);
      step();
      step();
      arst_n = 1'b0;
      #2;
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_valid", 32'(out_valid), 0);
      step();
      arst_n = 1'b1;
      multi = 0;
      for (int i = 0; i < 8; i++) begin
         if (out_valid) multi++;
         step();
      end
      chk("mid_rst_no_out", 32'(multi), 0);
      send(0, 16'h0100);
      wait_out(n);
      chk("mid_rst_data", 32'(out_data), 32'h0040);
      chk("mid_rst_ch", 32'(out_ch), 0);
      step();

      // Round-robin with all channels continuously valid
      arst_n = 1'b0;
      step();
      arst_n   = 1'b1;
      in_data  = 64'h0004_0003_0002_0001;
      in_valid = 4'hF;
      #1;
      multi = 0;
      for (int cyc = 0; cyc < 34; cyc++) begin
         if ($countones(in_ready) > 1) multi++;
         for (int c = 0; c < 4; c++) begin
            if (in_ready[c]) begin
               acc_cyc.push_back(cyc);
               acc_ch.push_back(c);
            end
         end
         if (out_valid) out_seq.push_back(int'(out_ch));
         step();
      end
      in_valid = '0;
      chk("rr_onehot", 32'(multi), 0);
      chk("rr_accepts", 32'(acc_ch.size()), 6);
      chk("rr_outputs", 32'(out_seq.size()), 5);
      for (int i = 0; i < 5; i++) begin
         if (i < acc_ch.size())
            chk($sformatf("rr_grant%0d", i), 32'(acc_ch[i]), 32'(i % 4));
         if (i < out_seq.size())
            chk($sformatf("rr_out%0d", i), 32'(out_seq[i]), 32'(i % 4));
         if (i > 0 && i < acc_cyc.size())
            chk($sformatf("rr_gap%0d", i),
                32'(acc_cyc[i] - acc_cyc[i-1]), 6);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
